ov5640_data_cap: RTL and testbench
==================================

OV5640_DATA_CAP -- requirements
Module: ov5640_data_cap

Interface
REQ-001 Parameter FRAME_SKIP, default 10: number of whole frames discarded after cfg_done before capture starts.
REQ-002 Parameter H_PIXEL, default 640: expected pixels per line.
REQ-003 Parameter V_PIXEL, default 480: expected lines per frame.
REQ-004 sys_clk  in  1  single clock, camera pixel clock; all logic on rising edge.
REQ-005 sys_rst  in  1  one clock; reset is asynchronous and active-high.
REQ-006 cfg_done  in  1  camera register configuration complete; level.
REQ-007 ov5640_vsync  in  1  frame sync, active high at frame start.
REQ-008 ov5640_href  in  1  line valid, high while pixel bytes are present.
REQ-009 ov5640_data  in  8  pixel byte, RGB565 high byte first.
REQ-010 pix_wr_req  out  1  one-cycle pixel write strobe to the write FIFO.
REQ-011 pix_wr_data  out  16  assembled RGB565 pixel, valid when pix_wr_req=1.
REQ-012 frame_start  out  1  one-cycle pulse at each captured frame start; usable as write-address reset.
REQ-013 frame_cnt  out  16  captured frame count, wraps 65535->0.
REQ-014 size_err  out  1  sticky line/frame size mismatch flag.

Function
REQ-015 vs_rise SHALL be ov5640_vsync=1 with the previous-cycle registered vsync=0; href_fall likewise for href 1->0.
REQ-016 FSM states: WAIT_CFG, SKIP, CAPTURE.
REQ-017 WAIT_CFG: cfg_done=1 -> SKIP, skip_cnt cleared to 0.
REQ-018 SKIP: on vs_rise, skip_cnt<FRAME_SKIP -> skip_cnt+1; skip_cnt==FRAME_SKIP -> CAPTURE. Capture begins on the (FRAME_SKIP+1)-th vs_rise; FRAME_SKIP=0 captures from the first vs_rise.
REQ-019 In any state, cfg_done=0 -> WAIT_CFG next cycle; byte phase, pixel/line counters and skip_cnt cleared; no further pix_wr_req.
REQ-020 frame_start SHALL pulse for one cycle, registered, the cycle after each vs_rise that enters CAPTURE or occurs in CAPTURE; frame_cnt increments in that same cycle.
REQ-021 On vs_rise in CAPTURE: x_cnt, y_cnt, and byte phase cleared.
REQ-022 In CAPTURE with href=1, byte phase toggles every cycle: phase 0 latches ov5640_data as high byte; phase 1 completes the pixel.
REQ-023 Pixel completion SHALL drive pix_wr_req=1 and pix_wr_data={high byte, current byte} in the next cycle (1-cycle latency); pix_wr_req is 0 in all other cycles.
REQ-024 pix_wr_data SHALL hold its last value when pix_wr_req=0.
REQ-025 x_cnt (12 bit) increments per completed pixel and saturates at 4095; y_cnt (11 bit) increments on href_fall and saturates at 2047.
REQ-026 On href_fall in CAPTURE: x_cnt!=H_PIXEL or odd byte count -> size_err=1; x_cnt cleared; an unpaired high byte is dropped; phase cleared.
REQ-027 On vs_rise in CAPTURE, excluding the rise that entered CAPTURE: y_cnt!=V_PIXEL -> size_err=1.
REQ-028 size_err SHALL clear only on reset.
REQ-029 href high outside CAPTURE SHALL produce no writes and no counter changes.
REQ-030 vs_rise coincident with href=1 in CAPTURE: frame restart takes priority; counters cleared; pixel in progress dropped.

Reset
REQ-031 sys_rst=1 SHALL asynchronously force state WAIT_CFG, pix_wr_req=0, pix_wr_data=0, frame_start=0, frame_cnt=0, size_err=0, all counters, the byte phase, and the vsync/href delay registers to 0.
REQ-032 Reset asserted mid-line SHALL discard any partial pixel; after release the block waits for cfg_done, then repeats the full skip sequence.

Verification (H_PIXEL=4, V_PIXEL=2, FRAME_SKIP=2 unless stated)
REQ-033 cfg_done=1, 3 vsync pulses, then 2 lines of 8 bytes 0x01..0x08 -> no writes after pulses 1-2; frame_start once after pulse 3; pix_wr_req x8; first pixels 0x0102, 0x0304; frame_cnt=1.
REQ-034 Same stream, then a 4th vsync -> frame_cnt=2, size_err=0.
REQ-035 A line of 6 bytes (3 pixels) in a captured frame -> 3 writes; size_err=1 after href_fall; size_err stays 1 through the next frames.
REQ-036 A line of 7 bytes -> 3 writes; byte 7 dropped; size_err=1.
REQ-037 cfg_done dropped mid-line -> no pix_wr_req from the next cycle; re-asserting cfg_done requires 3 more vsync pulses before writes resume.
REQ-038 sys_rst pulsed mid-capture -> all outputs 0 immediately, asynchronously to sys_clk; FRAME_SKIP=0 after release: first vsync pulse gives frame_start and capture.

Source files
------------

// File: rtl/ov5640_data_cap.sv
// OV5640 DVP capture: skips the first frames after configuration, then packs
// byte pairs into RGB565 write strobes and checks the line/frame geometry.
module ov5640_data_cap #(
    parameter int FRAME_SKIP = 10,
    parameter int H_PIXEL    = 640,
    parameter int V_PIXEL    = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_done,
    input  logic        ov5640_vsync,
    input  logic        ov5640_href,
    input  logic [7:0]  ov5640_data,
    output logic        pix_wr_req,
    output logic [15:0] pix_wr_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        size_err
);
    localparam int SKW = (FRAME_SKIP < 1) ? 1 : $clog2(FRAME_SKIP + 1);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'(FRAME_SKIP);
    localparam logic [11:0]    H_EXP     = 12'(H_PIXEL);
    localparam logic [10:0]    V_EXP     = 11'(V_PIXEL);

    typedef enum logic [1:0] {WAIT_CFG, SKIP, CAPTURE} state_t;
    state_t state, state_nxt;

    logic           vsync_d, href_d;
    logic           vs_rise, href_fall;
    logic [SKW-1:0] skip_cnt;
    logic [11:0]    x_cnt;
    logic [10:0]    y_cnt;
    logic           phase;
    logic [7:0]     hi_byte;

    assign vs_rise   = ov5640_vsync & ~vsync_d;
    assign href_fall = ~ov5640_href & href_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= WAIT_CFG;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!cfg_done) begin
            state_nxt = WAIT_CFG;
        end else begin
            case (state)
                WAIT_CFG: state_nxt = SKIP;
                SKIP:     if (vs_rise && skip_cnt == SKIP_LAST) state_nxt = CAPTURE;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_d     <= 1'b0;
            href_d      <= 1'b0;
            skip_cnt    <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            phase       <= 1'b0;
            hi_byte     <= '0;
            pix_wr_req  <= 1'b0;
            pix_wr_data <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            size_err    <= 1'b0;
        end else begin
            vsync_d     <= ov5640_vsync;
            href_d      <= ov5640_href;
            pix_wr_req  <= 1'b0;
            frame_start <= 1'b0;
            if (!cfg_done) begin
                skip_cnt <= '0;
                x_cnt    <= '0;
                y_cnt    <= '0;
                phase    <= 1'b0;
            end else begin
                case (state)
                    WAIT_CFG: skip_cnt <= '0;
                    SKIP: begin
                        if (vs_rise) begin
                            if (skip_cnt == SKIP_LAST) begin
                                frame_start <= 1'b1;
                                frame_cnt   <= frame_cnt + 16'd1;
                                x_cnt       <= '0;
                                y_cnt       <= '0;
                                phase       <= 1'b0;
                            end else begin
                                skip_cnt <= skip_cnt + 1'b1;
                            end
                        end
                    end
                    CAPTURE: begin
                        // Frame restart wins over any byte arriving in the same cycle.
                        if (vs_rise) begin
                            frame_start <= 1'b1;
                            frame_cnt   <= frame_cnt + 16'd1;
                            if (y_cnt != V_EXP) size_err <= 1'b1;
                            x_cnt <= '0;
                            y_cnt <= '0;
                            phase <= 1'b0;
                        end else if (href_fall) begin
                            if (x_cnt != H_EXP || phase) size_err <= 1'b1;
                            x_cnt <= '0;
                            phase <= 1'b0;
                            if (y_cnt != 11'h7FF) y_cnt <= y_cnt + 11'd1;
                        end else if (ov5640_href) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi_byte <= ov5640_data;
                            end else begin
                                pix_wr_req  <= 1'b1;
                                pix_wr_data <= {hi_byte, ov5640_data};
                                if (x_cnt != 12'hFFF) x_cnt <= x_cnt + 12'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ov5640_data_cap.sv
// Directed bench: a FRAME_SKIP=2 instance for the main scenarios and a
// FRAME_SKIP=0 instance sharing the same inputs for the post-reset check.
module tb_ov5640_data_cap;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_done = 1'b0;
    logic        ov5640_vsync = 1'b0;
    logic        ov5640_href = 1'b0;
    logic [7:0]  ov5640_data = 8'h00;
    logic        pix_wr_req, frame_start, size_err;
    logic [15:0] pix_wr_data, frame_cnt;
    logic        req0, fs0, serr0;
    logic [15:0] data0, fcnt0;

    int total = 0;
    int bad = 0;
    logic [15:0] wq[$];
    logic [15:0] wq0[$];
    int fs_seen = 0;
    int fs0_seen = 0;

    always #5 sys_clk = ~sys_clk;

    ov5640_data_cap #(.FRAME_SKIP(2), .H_PIXEL(4), .V_PIXEL(2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_done(cfg_done),
        .ov5640_vsync(ov5640_vsync), .ov5640_href(ov5640_href), .ov5640_data(ov5640_data),
        .pix_wr_req(pix_wr_req), .pix_wr_data(pix_wr_data), .frame_start(frame_start),
        .frame_cnt(frame_cnt), .size_err(size_err));

    ov5640_data_cap #(.FRAME_SKIP(0), .H_PIXEL(4), .V_PIXEL(2)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_done(cfg_done),
        .ov5640_vsync(ov5640_vsync), .ov5640_href(ov5640_href), .ov5640_data(ov5640_data),
        .pix_wr_req(req0), .pix_wr_data(data0), .frame_start(fs0),
        .frame_cnt(fcnt0), .size_err(serr0));

    always @(negedge sys_clk) begin
        if (pix_wr_req) wq.push_back(pix_wr_data);
        if (req0) wq0.push_back(data0);
        if (frame_start) fs_seen++;
        if (fs0) fs0_seen++;
    end

    task automatic vsync_pulse();
        @(negedge sys_clk) ov5640_vsync = 1'b1;
        @(negedge sys_clk) ov5640_vsync = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic send_line(input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            ov5640_href = 1'b1;
            ov5640_data = first + 8'(i);
        end
        @(negedge sys_clk) ov5640_href = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        total += 5;
        if (pix_wr_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", pix_wr_req); end
        if (pix_wr_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%h exp=0000", pix_wr_data); end
        if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", frame_start); end
        if (frame_cnt !== 16'h0) begin bad++; $display("FAIL rst_fcnt got=%0d exp=0", frame_cnt); end
        if (size_err !== 1'b0) begin bad++; $display("FAIL rst_serr got=%b exp=0", size_err); end
        sys_rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_capture();
        int n0, f0;
        n0 = wq.size();
        f0 = fs_seen;
        cfg_done = 1'b1;
        @(negedge sys_clk);
        vsync_pulse();
        send_line(8, 8'h01);
        total++;
        if (wq.size() != n0) begin bad++; $display("FAIL skip1_writes got=%0d exp=%0d", wq.size(), n0); end
        vsync_pulse();
        send_line(8, 8'h01);
        total += 2;
        if (wq.size() != n0) begin bad++; $display("FAIL skip2_writes got=%0d exp=%0d", wq.size(), n0); end
        if (fs_seen != f0) begin bad++; $display("FAIL skip_fs got=%0d exp=%0d", fs_seen, f0); end
        vsync_pulse();
        total++;
        if (fs_seen != f0 + 1) begin bad++; $display("FAIL cap_fs got=%0d exp=%0d", fs_seen, f0 + 1); end
        send_line(8, 8'h01);
        send_line(8, 8'h01);
        total += 5;
        if (wq.size() != n0 + 8) begin bad++; $display("FAIL cap_writes got=%0d exp=%0d", wq.size(), n0 + 8); end
        else begin
            if (wq[n0] !== 16'h0102) begin bad++; $display("FAIL cap_pix0 got=%h exp=0102", wq[n0]); end
            if (wq[n0+1] !== 16'h0304) begin bad++; $display("FAIL cap_pix1 got=%h exp=0304", wq[n0+1]); end
            if (wq[n0+7] !== 16'h0708) begin bad++; $display("FAIL cap_pix7 got=%h exp=0708", wq[n0+7]); end
        end
        if (frame_cnt !== 16'd1) begin bad++; $display("FAIL cap_fcnt got=%0d exp=1", frame_cnt); end
    endtask

    task automatic test_frame_end();
        vsync_pulse();
        total += 3;
        if (frame_cnt !== 16'd2) begin bad++; $display("FAIL fe_fcnt got=%0d exp=2", frame_cnt); end
        if (size_err !== 1'b0) begin bad++; $display("FAIL fe_serr got=%b exp=0", size_err); end
        if (fs_seen != 2) begin bad++; $display("FAIL fe_fs got=%0d exp=2", fs_seen); end
    endtask

    task automatic test_short_line();
        int n0;
        n0 = wq.size();
        send_line(6, 8'h21);
        total += 3;
        if (wq.size() != n0 + 3) begin bad++; $display("FAIL short_writes got=%0d exp=%0d", wq.size(), n0 + 3); end
        else if (wq[n0+2] !== 16'h2526) begin bad++; $display("FAIL short_pix2 got=%h exp=2526", wq[n0+2]); end
        if (size_err !== 1'b1) begin bad++; $display("FAIL short_serr got=%b exp=1", size_err); end
        send_line(8, 8'h01);
        vsync_pulse();
        total += 2;
        if (size_err !== 1'b1) begin bad++; $display("FAIL short_sticky got=%b exp=1", size_err); end
        if (frame_cnt !== 16'd3) begin bad++; $display("FAIL short_fcnt got=%0d exp=3", frame_cnt); end
    endtask

    task automatic test_odd_line();
        int n0;
        n0 = wq.size();
        send_line(7, 8'h01);
        total += 2;
        if (wq.size() != n0 + 3) begin bad++; $display("FAIL odd_writes got=%0d exp=%0d", wq.size(), n0 + 3); end
        else if (wq[n0+2] !== 16'h0506) begin bad++; $display("FAIL odd_pix2 got=%h exp=0506", wq[n0+2]); end
        if (size_err !== 1'b1) begin bad++; $display("FAIL odd_serr got=%b exp=1", size_err); end
        send_line(8, 8'h11);
        total++;
        if (wq.size() < n0 + 4) begin bad++; $display("FAIL odd_next_cnt got=%0d exp=%0d", wq.size(), n0 + 7); end
        else if (wq[n0+3] !== 16'h1112) begin bad++; $display("FAIL odd_next_pix got=%h exp=1112", wq[n0+3]); end
    endtask

    task automatic test_cfg_drop();
        int n0, f0;
        n0 = wq.size();
        f0 = fs_seen;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            ov5640_href = 1'b1;
            ov5640_data = 8'h01 + 8'(i);
            if (i == 2) cfg_done = 1'b0;
        end
        @(negedge sys_clk) ov5640_href = 1'b0;
        repeat (3) @(negedge sys_clk);
        total++;
        if (wq.size() != n0 + 1) begin bad++; $display("FAIL drop_writes got=%0d exp=%0d", wq.size(), n0 + 1); end
        cfg_done = 1'b1;
        @(negedge sys_clk);
        vsync_pulse();
        send_line(8, 8'h01);
        vsync_pulse();
        send_line(8, 8'h01);
        total += 2;
        if (wq.size() != n0 + 1) begin bad++; $display("FAIL drop_skip_writes got=%0d exp=%0d", wq.size(), n0 + 1); end
        if (fs_seen != f0) begin bad++; $display("FAIL drop_skip_fs got=%0d exp=%0d", fs_seen, f0); end
        vsync_pulse();
        send_line(8, 8'h31);
        total += 3;
        if (wq.size() != n0 + 5) begin bad++; $display("FAIL drop_resume got=%0d exp=%0d", wq.size(), n0 + 5); end
        else if (wq[n0+1] !== 16'h3132) begin bad++; $display("FAIL drop_pix got=%h exp=3132", wq[n0+1]); end
        if (fs_seen != f0 + 1) begin bad++; $display("FAIL drop_fs got=%0d exp=%0d", fs_seen, f0 + 1); end
        if (frame_cnt !== 16'd4) begin bad++; $display("FAIL drop_fcnt got=%0d exp=4", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int n0, m0, g0;
        @(negedge sys_clk);
        ov5640_href = 1'b1;
        ov5640_data = 8'h41;
        #3 sys_rst = 1'b1;
        #1;
        total += 7;
        if (pix_wr_req !== 1'b0) begin bad++; $display("FAIL arst_req got=%b exp=0", pix_wr_req); end
        if (pix_wr_data !== 16'h0) begin bad++; $display("FAIL arst_data got=%h exp=0000", pix_wr_data); end
        if (frame_start !== 1'b0) begin bad++; $display("FAIL arst_fs got=%b exp=0", frame_start); end
        if (frame_cnt !== 16'h0) begin bad++; $display("FAIL arst_fcnt got=%0d exp=0", frame_cnt); end
        if (size_err !== 1'b0) begin bad++; $display("FAIL arst_serr got=%b exp=0", size_err); end
        if (fcnt0 !== 16'h0) begin bad++; $display("FAIL arst_fcnt0 got=%0d exp=0", fcnt0); end
        if (serr0 !== 1'b0) begin bad++; $display("FAIL arst_serr0 got=%b exp=0", serr0); end
        @(negedge sys_clk);
        ov5640_href = 1'b0;
        sys_rst = 1'b0;
        n0 = wq.size();
        m0 = wq0.size();
        g0 = fs0_seen;
        vsync_pulse();
        total += 2;
        if (fs0_seen != g0 + 1) begin bad++; $display("FAIL skip0_fs got=%0d exp=%0d", fs0_seen, g0 + 1); end
        if (fcnt0 !== 16'd1) begin bad++; $display("FAIL skip0_fcnt got=%0d exp=1", fcnt0); end
        send_line(8, 8'h51);
        total += 2;
        if (wq0.size() != m0 + 4) begin bad++; $display("FAIL skip0_writes got=%0d exp=%0d", wq0.size(), m0 + 4); end
        else if (wq0[m0] !== 16'h5152) begin bad++; $display("FAIL skip0_pix got=%h exp=5152", wq0[m0]); end
        if (wq.size() != n0) begin bad++; $display("FAIL skip2_after_rst got=%0d exp=%0d", wq.size(), n0); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_frame_end();
        test_short_line();
        test_odd_line();
        test_cfg_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
